// File: rtl/cpu_defs.sv
// Shared fetch-front definitions: default vectors, redirect ranks, fetch FSM states
// and the sequential fetch-group address helper.
package cpu_defs;

    localparam logic [31:0] RESET_PC_DEF = 32'hbfc00000;
    localparam logic [31:0] EXC_VEC_DEF  = 32'hbfc00380;

    // Higher rank wins when a redirect is already buffered.
    typedef enum logic [1:0] {
        RANK_NONE = 2'd0,
        RANK_BR   = 2'd1,
        RANK_EXC  = 2'd2
    } rank_t;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    // Start of the next fetch group; grp is the group size in bytes (power of two).
    function automatic logic [31:0] seq_next(input logic [31:0] pc, input logic [31:0] grp);
        return (pc & ~(grp - 32'd1)) + grp;
    endfunction

endpackage

// File: rtl/redirect_sel.sv
// Priority select of redirect target and rank (exception > branch > eret), qualified
// against the rank of whatever redirect is currently buffered.
module redirect_sel
    import cpu_defs::*;
#(
    parameter logic [31:0] EXC_VEC = EXC_VEC_DEF
) (
    input  logic        exception,
    input  logic        br_take,
    input  logic        eret,
    input  logic [31:0] br_target,
    input  logic [31:0] epc,
    input  rank_t       buf_rank,
    output logic [31:0] target,
    output rank_t       rank,
    output logic        take
);

    logic req;

    always_comb begin
        target = epc;
        rank   = RANK_NONE;
        req    = 1'b0;
        if (exception) begin
            target = EXC_VEC;
            rank   = RANK_EXC;
            req    = 1'b1;
        end else if (br_take) begin
            target = br_target;
            rank   = RANK_BR;
            req    = 1'b1;
        end else if (eret) begin
            target = epc;
            rank   = RANK_BR;
            req    = 1'b1;
        end
    end

    // With nothing buffered (RANK_NONE) every request is taken; equal rank overwrites.
    assign take = req && (rank >= buf_rank);

endmodule

// File: rtl/pc_gen.sv
// Fetch-address generator: presents the fetch PC under a valid/ready handshake,
// advances by fetch groups and applies redirects, buffering them while stalled.
module pc_gen
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF,
    parameter int          FETCH_W  = 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               stall,
    input  logic               br_take,
    input  logic [31:0]        br_target,
    input  logic               exception,
    input  logic               eret,
    input  logic [31:0]        epc,
    output logic               pc_valid,
    input  logic               pc_ready,
    output logic [31:0]        pc,
    output logic [FETCH_W-1:0] slot_mask,
    output logic               pc_adel,
    output logic               flush
);

    localparam logic [31:0] GRP = 32'(FETCH_W * 4);

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] buf_target_reg, buf_target_next;
    rank_t       buf_rank_reg, buf_rank_next;
    logic        flush_reg, flush_next;

    logic [31:0] redir_target;
    rank_t       redir_rank;
    logic        redir_take;

    redirect_sel #(
        .EXC_VEC (EXC_VEC)
    ) u_redirect_sel (
        .exception (exception),
        .br_take   (br_take),
        .eret      (eret),
        .br_target (br_target),
        .epc       (epc),
        .buf_rank  (buf_rank_reg),
        .target    (redir_target),
        .rank      (redir_rank),
        .take      (redir_take)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg      <= ST_BOOT;
            pc_reg         <= RESET_PC;
            buf_target_reg <= '0;
            buf_rank_reg   <= RANK_NONE;
            flush_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            buf_target_reg <= buf_target_next;
            buf_rank_reg   <= buf_rank_next;
            flush_reg      <= flush_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        buf_target_next = buf_target_reg;
        buf_rank_next   = buf_rank_reg;
        flush_next      = 1'b0;
        case (state_reg)
            ST_BOOT: begin
                state_next = ST_RUN;
                if (redir_take) begin
                    pc_next    = redir_target;
                    flush_next = 1'b1;
                end
            end
            ST_RUN: begin
                if (redir_take) begin
                    // A request is outstanding and not accepted: the bus must not change.
                    if (!pc_ready) begin
                        buf_target_next = redir_target;
                        buf_rank_next   = redir_rank;
                        state_next      = ST_PEND;
                    end else begin
                        pc_next    = redir_target;
                        flush_next = 1'b1;
                    end
                end else if (pc_ready && !stall) begin
                    pc_next = seq_next(pc_reg, GRP);
                end
            end
            ST_PEND: begin
                if (redir_take) begin
                    buf_target_next = redir_target;
                    buf_rank_next   = redir_rank;
                end
                // The buffered redirect loads on acceptance regardless of stall.
                if (pc_ready) begin
                    pc_next         = redir_take ? redir_target : buf_target_reg;
                    flush_next      = 1'b1;
                    state_next      = ST_RUN;
                    buf_target_next = '0;
                    buf_rank_next   = RANK_NONE;
                end
            end
            default: begin
                state_next = ST_BOOT;
            end
        endcase
    end

    assign pc_valid = (state_reg != ST_BOOT);
    assign pc       = pc_reg;
    assign pc_adel  = (pc_reg[1:0] != 2'b00);
    assign flush    = flush_reg;

    generate
        if (FETCH_W == 1) begin : g_single
            assign slot_mask = 1'b1;
        end else begin : g_group
            localparam int OFFW = $clog2(FETCH_W);
            logic [OFFW-1:0] slot_off;
            assign slot_off = pc_reg[OFFW+1:2];
            for (genvar gi = 0; gi < FETCH_W; gi++) begin : g_slot
                assign slot_mask[gi] = (OFFW'(gi) >= slot_off);
            end
        end
    endgenerate

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch-address generator at the front of the pipeline. It holds the fetch PC and presents it to instruction fetch under a valid/ready handshake. It advances by fetch groups of FETCH_W instructions and redirects on exception, branch or eret. A redirect that arrives while a request is stalled at the handshake is buffered and applied when the handshake completes, so the presented address never changes while valid is high.

## Interface
- RESET_PC, 32'hbfc00000, PC loaded by reset.
- EXC_VEC, 32'hbfc00380, exception entry vector.
- FETCH_W, 1, instructions per fetch group. Legal values: 1, 2, 4.
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- stall  in  1  pipeline stall. Blocks the sequential advance only.
- br_take  in  1  branch redirect request.
- br_target  in  32  branch target.
- exception  in  1  exception redirect request.
- eret  in  1  eret redirect request.
- epc  in  32  eret target.
- pc_valid  out  1  fetch request valid.
- pc_ready  in  1  fetch stage accepts the request.
- pc  out  32  fetch address.
- slot_mask  out  FETCH_W  valid instruction slots in the group.
- pc_adel  out  1  pc[1:0] != 0. Fetch address error, accompanies the request.
- flush  out  1  one-cycle pulse: discard any in-flight fetch older than the new pc.

## Operation
- Group size G = FETCH_W*4 bytes. Sequential next = (pc & ~(G-1)) + G. Arithmetic is 32-bit and wraps at 2^32.
- slot_mask bit i = 1 iff i >= pc[log2(G)-1:2]. With FETCH_W=1 it is constantly 1.
- Redirect priority: exception > br_take > eret. Target is EXC_VEC, br_target or epc respectively.
- Rank of a redirect: exception = 2, branch/eret = 1.
- FSM states:
  - BOOT: the cycle after reset. pc=RESET_PC, pc_valid=0. Goes to RUN unconditionally.
  - RUN: pc_valid=1.
  - PEND: pc_valid=1, a redirect is buffered.
- RUN, redirect present:
  - If pc_valid && !pc_ready: store target and rank, go to PEND. pc stays unchanged.
  - Otherwise: pc <= target, flush=1 next cycle, stay in RUN.
- RUN, no redirect: if pc_valid && pc_ready && !stall, pc <= sequential next. Otherwise pc holds.
- PEND:
  - A new redirect with rank >= buffered rank overwrites the buffer. A lower rank is dropped.
  - When pc_ready=1: pc <= buffered target (or the overwriting target in the same cycle), flush=1 next cycle, go to RUN. stall is ignored for this load.
- Redirect in BOOT: pc <= target, flush=1, go to RUN.
- pc_adel is purely a function of pc. It is not checked against the redirect source.

## Timing
- Reset values: pc=RESET_PC, pc_valid=0, flush=0, state=BOOT. slot_mask is as computed from RESET_PC. Buffer is cleared.
- First valid request appears 1 cycle after resetn rises.
- Redirect to new pc on the bus: 1 cycle when not blocked. When blocked, 1 cycle after the accepting pc_ready.
- flush is asserted in the same cycle the redirected pc is first presented.
- pc, slot_mask and pc_adel are stable while pc_valid && !pc_ready.
- Reset asserted mid-PEND: buffer discarded, back to BOOT.

## Structure
- Shared package `cpu_defs`: EXC_VEC default, RESET_PC default, redirect rank encodings, FSM state enum.
- One sub-module, `redirect_sel`: combinational priority select of target and rank. Reused by the pending-buffer compare logic.

## Test plan
- Reset, then pc_ready=1, FETCH_W=1 -> pc 0xbfc00000, 0xbfc00004, 0xbfc00008; pc_valid low only in the first cycle.
- FETCH_W=4, br_target=0x80001008, pc_ready=1 -> pc=0x80001008, slot_mask=4'b1100, flush=1; next pc=0x80001010, mask 4'b1111.
- pc_ready=0 with pc=0x80000020, br_take to 0x80000100 -> pc holds 0x80000020 for 3 cycles. pc_ready=1 -> next pc 0x80000100 with flush=1.
- In PEND (branch buffered), exception arrives -> buffer holds 0xbfc00380. A later eret with epc 0x80000400 is dropped. Accept -> pc=0xbfc00380.
- exception, br_take and eret in the same cycle -> pc=0xbfc00380. br_take and eret together -> br_target wins.
- eret with epc=0x80000002 -> pc=0x80000002, pc_adel=1. Also: stall=1 with no redirect -> pc holds. pc=0xfffffffc sequential -> pc=0x00000000.
